// File: rtl/ps2_keypad_multidigit.sv
// PS/2 keyboard receiver with deglitched clock, frame checking and watchdog, feeding
// numeric make codes into an N-digit seven-segment scroll register.
module ps2_keypad_multidigit #(
  parameter int NUM_DIGITS     = 4,
  parameter int FILTER_LEN     = 6,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  input  logic                    clear,
  output logic [7*NUM_DIGITS-1:0] hex_display,
  output logic [7:0]              scan_code,
  output logic                    scan_valid,
  output logic                    key_released,
  output logic                    frame_error,
  output logic [3:0]              digit_count
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Returns {is_digit, value} for a make code.
  function automatic logic [4:0] digit_decode(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      8'h45:   r = 5'h10;
      8'h16:   r = 5'h11;
      8'h1E:   r = 5'h12;
      8'h26:   r = 5'h13;
      8'h25:   r = 5'h14;
      8'h2E:   r = 5'h15;
      8'h36:   r = 5'h16;
      8'h3D:   r = 5'h17;
      8'h3E:   r = 5'h18;
      8'h46:   r = 5'h19;
      default: r = 5'h0F;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  logic [1:0]     clk_sync_q, clk_sync_d;
  logic [1:0]     dat_sync_q, dat_sync_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           filt_clk_q, filt_clk_d;
  logic           strobe, bit_in;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           shift_en, par_en, stop_en, wd_hit;
  logic           frame_good, frame_bad;

  logic [7:0]     scan_code_q, scan_code_d;
  logic           scan_valid_q, scan_valid_d;
  logic           key_rel_q, key_rel_d;
  logic           ferr_q, ferr_d;
  logic           brk_q, brk_d;
  logic           ext_q, ext_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     digits_q [NUM_DIGITS];
  logic [3:0]     digits_d [NUM_DIGITS];
  logic [4:0]     dec;

  // A filtered level change needs FILTER_LEN consecutive differing samples.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    filt_cnt_d = filt_cnt_q;
    filt_clk_d = filt_clk_q;
    if (clk_sync_q[1] == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
      filt_clk_d = clk_sync_q[1];
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign strobe = filt_clk_q & ~filt_clk_d;
  assign bit_in = dat_sync_q[1];
  assign wd_hit = (state_q != S_IDLE) && !strobe && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    if (wd_hit) begin
      state_d = S_IDLE;
    end else if (strobe) begin
      case (state_q)
        S_IDLE:   if (!bit_in) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = strobe && (state_q == S_DATA);
    par_en   = strobe && (state_q == S_PARITY);
    stop_en  = strobe && (state_q == S_STOP);
  end

  always_comb begin
    bit_cnt_d = (state_q == S_IDLE) ? 3'd0 : bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    if (shift_en) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shreg_d   = {bit_in, shreg_q[7:1]};
    end
    if (par_en) par_d = bit_in;
    if ((state_q == S_IDLE) || strobe || wd_hit) wd_d = '0;
    else                                         wd_d = wd_q + 1'b1;
  end

  // Odd parity over data plus parity bit, and a high stop bit.
  assign frame_good = stop_en && bit_in && (^{shreg_q, par_q});
  assign frame_bad  = (stop_en && !frame_good) || wd_hit;
  assign dec        = digit_decode(shreg_q);

  always_comb begin
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    key_rel_d    = 1'b0;
    ferr_d       = ferr_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    cnt_d        = cnt_q;
    digits_d     = digits_q;
    if (frame_bad) ferr_d = 1'b1;
    if (frame_good) begin
      scan_code_d  = shreg_q;
      scan_valid_d = 1'b1;
      ferr_d       = 1'b0;
      if (shreg_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shreg_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q) begin
        key_rel_d = 1'b1;
        brk_d     = 1'b0;
        ext_d     = 1'b0;
      end else if (ext_q) begin
        ext_d = 1'b0;
      end else if (dec[4]) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) digits_d[i] = digits_q[i-1];
        digits_d[0] = dec[3:0];
        if (cnt_q < 4'(NUM_DIGITS)) cnt_d = cnt_q + 4'd1;
      end
    end
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = 4'hF;
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      filt_cnt_q   <= '0;
      filt_clk_q   <= 1'b1;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      par_q        <= 1'b0;
      wd_q         <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      key_rel_q    <= 1'b0;
      ferr_q       <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      cnt_q        <= 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'hF;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      filt_cnt_q   <= filt_cnt_d;
      filt_clk_q   <= filt_clk_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      wd_q         <= wd_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      key_rel_q    <= key_rel_d;
      ferr_q       <= ferr_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    assign hex_display[7*g +: 7] = seg7(digits_q[g]);
  end

  assign scan_code    = scan_code_q;
  assign scan_valid   = scan_valid_q;
  assign key_released = key_rel_q;
  assign frame_error  = ferr_q;
  assign digit_count  = cnt_q;

endmodule

// File: tb/tb_ps2_keypad_multidigit.sv
// Scoreboard bench for ps2_keypad_multidigit: directed PS/2 frames, expected results
// queued at issue time and checked by a monitor whenever scan_valid pulses.
module tb_ps2_keypad_multidigit;

  localparam int ND   = 4;
  localparam int TO   = 1000;
  localparam int HALF = 20;
  localparam logic [6:0] BL = 7'h7F;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ps2_clk, ps2_data, clear;
  logic [7*ND-1:0] hex_display;
  logic [7:0]    scan_code;
  logic          scan_valid, key_released, frame_error;
  logic [3:0]    digit_count;

  ps2_keypad_multidigit #(
    .NUM_DIGITS(ND), .FILTER_LEN(6), .TIMEOUT_CYCLES(TO), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .clear(clear),
    .hex_display(hex_display), .scan_code(scan_code), .scan_valid(scan_valid),
    .key_released(key_released), .frame_error(frame_error), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      code;
    logic            kr;
    logic [7*ND-1:0] hex;
    logic [3:0]      cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;

  function automatic logic [7*ND-1:0] h4(logic [6:0] d3, logic [6:0] d2, logic [6:0] d1, logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(logic [7:0] code, logic kr, logic [7*ND-1:0] hex, logic [3:0] cnt);
    exp_t e;
    e.code = code; e.kr = kr; e.hex = hex; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] b, logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    tick(HALF);
  endtask

  // Monitor: every scan_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (scan_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_scan_valid: got code %h, expected no pulse", scan_code);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (scan_code !== e.code || key_released !== e.kr ||
              hex_display !== e.hex || digit_count !== e.cnt) begin
            miscompares++;
            $display("FAIL frame_%h: got code=%h kr=%b hex=%h cnt=%0d, expected code=%h kr=%b hex=%h cnt=%0d",
                     e.code, scan_code, key_released, hex_display, digit_count,
                     e.code, e.kr, e.hex, e.cnt);
          end
        end
      end else if (key_released) begin
        vectors++;
        miscompares++;
        $display("FAIL key_released_alone: got 1, expected 0 without scan_valid");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7*ND-1:0] held;
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    clear    = 1'b0;
    tick(5);
    check("rst_scan_code", 32'(scan_code), 32'h00);
    check("rst_scan_valid", 32'(scan_valid), 32'h0);
    check("rst_key_released", 32'(key_released), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_digit_count", 32'(digit_count), 32'h0);
    check("rst_hex", 32'(hex_display), 32'h0FFFFFFF);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick(30);

    push(8'h16, 1'b0, h4(BL, BL, BL, 7'h79), 4'd1);       send_frame(8'h16, 1'b0);
    push(8'h1E, 1'b0, h4(BL, BL, 7'h79, 7'h24), 4'd2);    send_frame(8'h1E, 1'b0);
    push(8'h26, 1'b0, h4(BL, 7'h79, 7'h24, 7'h30), 4'd3); send_frame(8'h26, 1'b0);
    push(8'h25, 1'b0, h4(7'h79, 7'h24, 7'h30, 7'h19), 4'd4); send_frame(8'h25, 1'b0);
    push(8'h2E, 1'b0, h4(7'h24, 7'h30, 7'h19, 7'h12), 4'd4); send_frame(8'h2E, 1'b0);

    push(8'hF0, 1'b0, h4(7'h24, 7'h30, 7'h19, 7'h12), 4'd4); send_frame(8'hF0, 1'b0);
    push(8'h26, 1'b1, h4(7'h24, 7'h30, 7'h19, 7'h12), 4'd4); send_frame(8'h26, 1'b0);

    push(8'hE0, 1'b0, h4(7'h24, 7'h30, 7'h19, 7'h12), 4'd4); send_frame(8'hE0, 1'b0);
    push(8'h45, 1'b0, h4(7'h24, 7'h30, 7'h19, 7'h12), 4'd4); send_frame(8'h45, 1'b0);
    push(8'h45, 1'b0, h4(7'h30, 7'h19, 7'h12, 7'h40), 4'd4); send_frame(8'h45, 1'b0);

    held = h4(7'h30, 7'h19, 7'h12, 7'h40);
    send_frame(8'h16, 1'b1);
    check("bad_parity_frame_error", 32'(frame_error), 32'h1);
    check("bad_parity_hex_held", 32'(hex_display), 32'(held));
    check("bad_parity_scan_code_held", 32'(scan_code), 32'h45);

    push(8'h3E, 1'b0, h4(7'h19, 7'h12, 7'h40, 7'h00), 4'd4); send_frame(8'h3E, 1'b0);
    check("good_clears_frame_error", 32'(frame_error), 32'h0);

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    tick(TO + 100);
    check("timeout_frame_error", 32'(frame_error), 32'h1);

    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(1);
    ps2_clk  = 1'b1;
    tick(30);
    ps2_data = 1'b1;
    tick(10);
    push(8'h46, 1'b0, h4(7'h12, 7'h40, 7'h00, 7'h10), 4'd4); send_frame(8'h46, 1'b0);
    check("post_timeout_frame_error", 32'(frame_error), 32'h0);

    clear = 1'b1;
    push(8'h16, 1'b0, h4(BL, BL, BL, BL), 4'd0); send_frame(8'h16, 1'b0);
    clear = 1'b0;
    tick(5);
    check("clear_hex_blank", 32'(hex_display), 32'h0FFFFFFF);
    check("clear_digit_count", 32'(digit_count), 32'h0);

    push(8'h1E, 1'b0, h4(BL, BL, BL, 7'h24), 4'd1); send_frame(8'h1E, 1'b0);

    tick(20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_keypad_multidigit.md
Name: ps2_keypad_multidigit

Overview:
- Parametrised successor to the single-digit PS/2 number display.
- Receives PS/2 keyboard frames with clock deglitching, full frame checking (start/odd parity/stop) and a frame watchdog.
- Decodes make/break (F0) and extended (E0) prefixes; shifts numeric keys 0-9 into an N-digit seven-segment scroll register.
- Sits between the keyboard pins and the board's HEX displays; also exports raw scan codes to downstream logic.

Parameters:
- NUM_DIGITS, 4, number of seven-segment digits driven (1..8).
- FILTER_LEN, 6, consecutive identical clk samples required before filtered ps2_clk changes (2..16).
- TIMEOUT_CYCLES, 50000, clk cycles without a filtered ps2_clk falling edge mid-frame before the frame is aborted.
- SEG_ACTIVE_LOW, 1, 1: segment on = 0 (board default); 0: segment on = 1.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ps2_clk  in  1  raw keyboard clock (input only; never driven).
- ps2_data  in  1  raw keyboard data.
- clear  in  1  synchronous: blanks all digits, zeroes digit_count.
- hex_display  out  7*NUM_DIGITS  digit i at bits [7i+6:7i]; digit 0 = newest; segment order g..a, MSB to LSB.
- scan_code  out  8  last good frame byte.
- scan_valid  out  1  one-cycle pulse per good frame (including F0/E0 bytes).
- key_released  out  1  one-cycle pulse when a byte following F0 is received.
- frame_error  out  1  sticky; set on a bad frame or timeout, cleared by the next good frame.
- digit_count  out  4  number of digits entered since reset/clear; saturates at NUM_DIGITS.

Behaviour:
- Reset (reset=0) effects:
  - Outputs: scan_code=00, scan_valid=0, key_released=0, frame_error=0, digit_count=0.
  - All digits blank (value 15; all segments off per SEG_ACTIVE_LOW).
  - FSM returns to IDLE; the break and extended flags are cleared.
  - Reset applied mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - Filtered clock updates only after FILTER_LEN equal consecutive synced samples.
  - A filtered 1->0 transition produces a one-cycle sample strobe; data is sampled from the synced ps2_data on that cycle.
- Frame FSM (advances on each sample strobe):
  - IDLE: bit=0 -> DATA with count=0; bit=1 -> stay IDLE (no error).
  - DATA: shift bits LSB first; after 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: good if the stop bit is 1 and the 9 bits (data plus parity) have an odd number of 1s. Result is applied on the next clk, then -> IDLE.
  - Bad frame: frame_error=1, no scan_valid, scan_code unchanged, prefix flags unchanged.
- Watchdog:
  - While not IDLE, a counter runs and resets on every strobe.
  - Reaching TIMEOUT_CYCLES: -> IDLE, frame_error=1, partial byte discarded.
- Good frame: one clk after the stop strobe, scan_code=byte, scan_valid=1, frame_error=0. Then, by byte:
  - F0: set the break flag; no digit action.
  - E0: set the extended flag; no digit action.
  - Any other byte with the break flag set: key_released=1; clear both flags; no digit action.
  - Any other byte with the extended flag set (no break): clear the extended flag; no digit action.
  - Otherwise (plain make code):
    - Codes 45,16,1E,26,25,2E,36,3D,3E,46 map to 0..9.
    - A digit code shifts: digit i <- digit i-1, digit 0 <- value, oldest digit dropped; digit_count+1, saturating.
    - Non-digit make codes: no shift.
- Display:
  - hex_display is combinational from the digit registers, so a new digit is visible in the same cycle as scan_valid.
  - Patterns 0-9, active-low: 40,79,24,30,19,12,02,78,00,10 (hex, 7 bits). Value 15 = all segments off. Bits are inverted when SEG_ACTIVE_LOW=0.
- Simultaneous events: if clear and a digit shift occur in the same cycle, clear wins (scan_valid still pulses).

Test Plan:
- Reset, then frame 0x16 (start 0, bits 0110_1000 LSB first, parity 0, stop 1) -> scan_valid 1 cycle, scan_code=16, digit0=79, digits1-3 blank, digit_count=1.
- Make codes 1E,26,25,2E -> digits 3..0 = 24,30,19,12 (the "1" has shifted out); digit_count=4.
- Key 0x26 with break sequence F0,26 -> two scan_valid pulses, key_released pulses on the second, digits unchanged.
- Frames E0,45 then 45 -> first 45 ignored, second shifts 0 (pattern 40) into digit0.
- Frame 0x16 with a wrong parity bit -> frame_error=1, no scan_valid, display unchanged; the next good 0x3E clears frame_error and shows 00 at digit0.
- Stop ps2_clk after 4 data bits for more than TIMEOUT_CYCLES -> frame_error=1, FSM IDLE; a 1-cycle glitch on ps2_clk (less than FILTER_LEN cycles) causes no strobe. Assert clear together with a digit frame -> all digits blank, digit_count=0.
